// File: rtl/div_seq_62by32.sv
// div_seq_62by32: sequential unsigned radix-2 restoring divider, DW-bit dividend by VW-bit divisor
//
// Ports:
//   clk          rising-edge clock
//   rst_n        asynchronous active-low reset
//   in_valid     dividend/divisor present
//   in_ready     block can accept an operation (high only in IDLE)
//   dividend     DW-bit unsigned dividend
//   divisor      VW-bit unsigned divisor
//   out_valid    result present (high only in DONE)
//   out_ready    consumer accepts result
//   quotient     DW-bit unsigned quotient
//   remainder    VW-bit unsigned remainder
//   div_by_zero  result came from a zero divisor
module div_seq_62by32 #(
    parameter int DW = 62,
    parameter int VW = 32
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic [DW-1:0] dividend,
    input  logic [VW-1:0] divisor,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [DW-1:0] quotient,
    output logic [VW-1:0] remainder,
    output logic          div_by_zero
);
    localparam int CW = $clog2(DW);
    typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;
    state_t        state, state_nx;
    logic [DW-1:0] sr;
    logic [VW-1:0] pr;
    logic [VW-1:0] dv;
    logic [CW-1:0] cnt;
    logic [VW:0]   trial;
    logic [VW:0]   diff;
    logic          ge;
    logic [DW-1:0] sr_nx;
    logic [VW-1:0] pr_nx;
    // sr shifts dividend bits out at the top while quotient bits enter at the
    // bottom, so after DW steps it holds the complete quotient.
    // pr always stays below the divisor, so the VW+1-bit trial value cannot
    // overflow, and trial - divisor < divisor whenever the subtraction succeeds;
    // bit VW of the difference is therefore exactly the borrow.
    always_comb begin
        trial = {pr, sr[DW-1]};
        diff  = trial - {1'b0, dv};
        ge    = ~diff[VW];
        pr_nx = ge ? diff[VW-1:0] : trial[VW-1:0];
        sr_nx = {sr[DW-2:0], ge};
    end
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nx;
    end
    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    state_nx = in_valid ? ((divisor == '0) ? DONE : CALC) : IDLE;
            CALC:    state_nx = (cnt == '0) ? DONE : CALC;
            DONE:    state_nx = out_ready ? IDLE : DONE;
            default: state_nx = IDLE;
        endcase
    end
    always_comb begin
        in_ready  = (state == IDLE);
        out_valid = (state == DONE);
    end
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sr          <= '0;
            pr          <= '0;
            dv          <= '0;
            cnt         <= '0;
            quotient    <= '0;
            remainder   <= '0;
            div_by_zero <= 1'b0;
        end else if (state == IDLE && in_valid) begin
            if (divisor == '0) begin
                quotient    <= '1;
                remainder   <= dividend[VW-1:0];
                div_by_zero <= 1'b1;
            end else begin
                sr          <= dividend;
                pr          <= '0;
                dv          <= divisor;
                cnt         <= CW'(DW - 1);
                div_by_zero <= 1'b0;
            end
        end else if (state == CALC) begin
            sr  <= sr_nx;
            pr  <= pr_nx;
            cnt <= cnt - CW'(1);
            if (cnt == '0) begin
                quotient  <= sr_nx;
                remainder <= pr_nx;
            end
        end
    end
endmodule

// File: tb/tb_div_seq_62by32.sv
// tb_div_seq_62by32: directed self-checking bench for div_seq_62by32
module tb_div_seq_62by32;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [61:0] dividend = '0;
    logic [31:0] divisor = '0;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [61:0] quotient;
    logic [31:0] remainder;
    logic        div_by_zero;
    int          checks = 0;
    int          errors = 0;
    logic [31:0] ra, rb, rc;
    logic [61:0] rprod;

    div_seq_62by32 dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .dividend(dividend), .divisor(divisor), .out_valid(out_valid),
        .out_ready(out_ready), .quotient(quotient), .remainder(remainder),
        .div_by_zero(div_by_zero)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic do_op(input string tag, input logic [61:0] a, input logic [31:0] b,
                         input logic [61:0] eq, input logic [31:0] er, input logic ed,
                         input int el, input bit consume);
        int lat;
        @(negedge clk);
        check({tag, ".in_ready_idle"}, 64'(in_ready), 64'd1);
        in_valid = 1'b1;
        dividend = a;
        divisor  = b;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        dividend = 62'h2AAA_AAAA_AAAA_AAAA;
        divisor  = 32'h1;
        lat = 0;
        while (!out_valid && lat < 200) begin
            @(posedge clk);
            #1;
            lat++;
        end
        check({tag, ".latency"}, 64'(lat), 64'(el));
        check({tag, ".quotient"}, 64'(quotient), 64'(eq));
        check({tag, ".remainder"}, 64'(remainder), 64'(er));
        check({tag, ".div_by_zero"}, 64'(div_by_zero), 64'(ed));
        check({tag, ".in_ready_done"}, 64'(in_ready), 64'd0);
        if (consume) begin
            @(negedge clk);
            out_ready = 1'b1;
            @(posedge clk);
            #1;
            out_ready = 1'b0;
            check({tag, ".out_valid_after"}, 64'(out_valid), 64'd0);
            check({tag, ".in_ready_after"}, 64'(in_ready), 64'd1);
        end
    endtask

    initial begin
        #1;
        check("reset.in_ready", 64'(in_ready), 64'd1);
        check("reset.out_valid", 64'(out_valid), 64'd0);
        check("reset.quotient", 64'(quotient), 64'd0);
        check("reset.remainder", 64'(remainder), 64'd0);
        check("reset.div_by_zero", 64'(div_by_zero), 64'd0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;

        do_op("basic", 62'd100, 32'd7, 62'd14, 32'd2, 1'b0, 62, 1'b1);
        do_op("roundtrip", 62'h3FFF_FFFE_C000_0001, 32'h3FFF_FFFF, 62'hFFFF_FFFF, 32'd0, 1'b0, 62, 1'b1);
        do_op("max_by_one", 62'h3FFF_FFFF_FFFF_FFFF, 32'd1, 62'h3FFF_FFFF_FFFF_FFFF, 32'd0, 1'b0, 62, 1'b1);
        do_op("small_by_max", 62'd5, 32'hFFFF_FFFF, 62'd0, 32'd5, 1'b0, 62, 1'b1);
        do_op("max_by_max", 62'h3FFF_FFFF_FFFF_FFFF, 32'hFFFF_FFFF, 62'h4000_0000, 32'h3FFF_FFFF, 1'b0, 62, 1'b1);
        do_op("lt_divisor", 62'd7, 32'd8, 62'd0, 32'd7, 1'b0, 62, 1'b1);
        do_op("equal", 62'hDEAD_BEEF, 32'hDEAD_BEEF, 62'd1, 32'd0, 1'b0, 62, 1'b1);
        do_op("zero_div", 62'h123, 32'd0, 62'h3FFF_FFFF_FFFF_FFFF, 32'h123, 1'b1, 0, 1'b1);
        do_op("after_zero", 62'd9, 32'd3, 62'd3, 32'd0, 1'b0, 62, 1'b1);

        for (int i = 0; i < 20; i++) begin
            ra = $urandom_range(32'h3FFF_FFFF, 0);
            rb = $urandom | 32'h1;
            rc = $urandom % rb;
            rprod = {30'b0, ra} * {30'b0, rb} + {30'b0, rc};
            do_op("random", rprod, rb, {30'b0, ra}, rc, 1'b0, 62, 1'b1);
        end

        do_op("bp", 62'd1000, 32'd3, 62'd333, 32'd1, 1'b0, 62, 1'b0);
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            in_valid = 1'b1;
            dividend = 62'd77;
            divisor  = 32'd7;
            @(posedge clk);
            #1;
            check("bp.out_valid", 64'(out_valid), 64'd1);
            check("bp.quotient", 64'(quotient), 64'd333);
            check("bp.remainder", 64'(remainder), 64'd1);
            check("bp.in_ready", 64'(in_ready), 64'd0);
        end
        @(negedge clk);
        in_valid  = 1'b0;
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        check("bp.release_out_valid", 64'(out_valid), 64'd0);
        check("bp.release_in_ready", 64'(in_ready), 64'd1);
        check("bp.idle_quotient_held", 64'(quotient), 64'd333);
        @(posedge clk);
        #1;
        check("bp.idle_stays", 64'(in_ready), 64'd1);
        check("bp.no_second_result", 64'(out_valid), 64'd0);

        @(negedge clk);
        in_valid = 1'b1;
        dividend = 62'd1000;
        divisor  = 32'd7;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        repeat (29) @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        check("rst.out_valid", 64'(out_valid), 64'd0);
        check("rst.in_ready", 64'(in_ready), 64'd1);
        check("rst.quotient", 64'(quotient), 64'd0);
        check("rst.remainder", 64'(remainder), 64'd0);
        check("rst.div_by_zero", 64'(div_by_zero), 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        do_op("post_rst", 62'd50, 32'd8, 62'd6, 32'd2, 1'b0, 62, 1'b1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
